// File: rtl/lcd_pkg.sv
// Shared opcodes, row addresses, microsecond delays and state types for the LCD controller.
// LCD_4BIT_MODE_EN selects the nibble-wide panel bus; undefined gives the 8-bit bus.
package lcd_pkg;

   typedef enum logic [1:0] {PWR_WAIT, INIT, DRAW, IDLE} ctrl_state_t;
   typedef enum logic [1:0] {X_IDLE, X_SETUP, X_EHIGH, X_WAIT} xfer_state_t;

`ifdef LCD_4BIT_MODE_EN
   localparam bit FOUR_BIT = 1'b1;
`else
   localparam bit FOUR_BIT = 1'b0;
`endif

   localparam int WAIT_W = 15;

   typedef struct packed {
      logic              nib_only;
      logic [7:0]        code;
      logic [WAIT_W-1:0] wait_us;
   } lcd_cmd_t;

   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;
   localparam logic [7:0] CMD_DISP_OFF = 8'h08;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_WAKE     = 8'h30;
   localparam logic [7:0] CMD_NIB4     = 8'h20;
   localparam logic [7:0] CMD_FSET8_2L = 8'h38;
   localparam logic [7:0] CMD_FSET8_1L = 8'h30;
   localparam logic [7:0] CMD_FSET4_2L = 8'h28;
   localparam logic [7:0] CMD_FSET4_1L = 8'h20;
   localparam logic [7:0] CMD_DDRAM    = 8'h80;

   localparam int                US_PWR   = 20000;
   localparam logic [WAIT_W-1:0] US_WAKE1 = 15'd4100;
   localparam logic [WAIT_W-1:0] US_WAKE2 = 15'd100;
   localparam logic [WAIT_W-1:0] US_CLEAR = 15'd2000;
   localparam logic [WAIT_W-1:0] US_CMD   = 15'd50;

   function automatic logic [7:0] row_base(input logic [1:0] row);
      logic [7:0] b;
      case (row)
         2'd0:    b = 8'h00;
         2'd1:    b = 8'h40;
         2'd2:    b = 8'h14;
         default: b = 8'h54;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/lcd_byte_xfer.sv
// One panel transfer: 1 us setup, 1 us E-high, then the command's post-wait.
// Under LCD_4BIT_MODE_EN a byte goes out as high then low nibble on data[7:4].
module lcd_byte_xfer
   import lcd_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic              in_Clk,
   input  logic              reset,
   input  logic              start,
   input  logic              rs,
   input  logic [7:0]        byte_in,
   input  logic [WAIT_W-1:0] wait_us,
   input  logic              nib_only,
   output logic              ready,
   output logic              lcd_rs,
   output logic              lcd_e,
   output logic [7:0]        data
);

   localparam int CYC_US = CLK_HZ / 1_000_000;
   localparam int CW     = $clog2(US_PWR * CYC_US + 1);
   localparam logic [CW-1:0] US_END = CW'(CYC_US - 1);

   xfer_state_t       state, state_n;
   logic [CW-1:0]     cnt, cnt_n, wait_end;
   logic              rs_q, rs_n, nib_q, nib_n, lo_q, lo_n;
   logic [7:0]        byte_q, byte_n, data_q, data_n;
   logic [WAIT_W-1:0] wait_q, wait_n;

   always_ff @(posedge in_Clk) begin
      if (!reset) begin
         state  <= X_IDLE;
         cnt    <= '0;
         rs_q   <= 1'b0;
         nib_q  <= 1'b0;
         lo_q   <= 1'b0;
         byte_q <= 8'h00;
         data_q <= 8'h00;
         wait_q <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         rs_q   <= rs_n;
         nib_q  <= nib_n;
         lo_q   <= lo_n;
         byte_q <= byte_n;
         data_q <= data_n;
         wait_q <= wait_n;
      end
   end

   // ready also covers the final wait cycle so the next setup starts with no gap
   always_comb begin
      state_n  = state;
      cnt_n    = cnt + CW'(1);
      rs_n     = rs_q;
      nib_n    = nib_q;
      lo_n     = lo_q;
      byte_n   = byte_q;
      data_n   = data_q;
      wait_n   = wait_q;
      wait_end = CW'(wait_q) * CW'(CYC_US) - CW'(1);
      ready    = (state == X_IDLE) || ((state == X_WAIT) && (cnt == wait_end));
      case (state)
         X_IDLE:  cnt_n = '0;
         X_SETUP: if (cnt == US_END) begin
            state_n = X_EHIGH;
            cnt_n   = '0;
         end
         X_EHIGH: if (cnt == US_END) begin
            cnt_n = '0;
            if (FOUR_BIT && !lo_q && !nib_q) begin
               state_n = X_SETUP;
               lo_n    = 1'b1;
               data_n  = {byte_q[3:0], 4'h0};
            end else begin
               state_n = X_WAIT;
            end
         end
         X_WAIT:  if (cnt == wait_end) begin
            state_n = X_IDLE;
            cnt_n   = '0;
         end
         default: state_n = X_IDLE;
      endcase
      if (start && ready) begin
         state_n = X_SETUP;
         cnt_n   = '0;
         rs_n    = rs;
         nib_n   = nib_only;
         lo_n    = 1'b0;
         byte_n  = byte_in;
         wait_n  = wait_us;
         data_n  = FOUR_BIT ? {byte_in[7:4], 4'h0} : byte_in;
      end
   end

   assign lcd_rs = rs_q;
   assign lcd_e  = (state == X_EHIGH);
   assign data   = data_q;

endmodule

// File: rtl/lcd_text_ctrl.sv
// HD44780 text controller: power-on wait, init list, frame buffer and redraw sequencing.
// LCD_4BIT_MODE_EN switches the init list and transfers to the 4-bit panel bus.
module lcd_text_ctrl
   import lcd_pkg::*;
#(
   parameter  int CLK_HZ = 50_000_000,
   parameter  int COLS   = 16,
   parameter  int ROWS   = 2,
   localparam int N      = ROWS * COLS,
   localparam int AW     = (N > 1) ? $clog2(N) : 1
) (
   input  logic          in_Clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic          refresh,
   output logic          busy,
   output logic          init_done,
   output logic          lcd_rs,
   output logic          lcd_rw,
   output logic          lcd_e,
   output logic [7:0]    data
);

   localparam int CYC_US  = CLK_HZ / 1_000_000;
   localparam int PWR_CYC = US_PWR * CYC_US;
   localparam int CW      = $clog2(PWR_CYC + 1);
   localparam logic [CW-1:0] PWR_END = CW'(PWR_CYC - 1);
   localparam logic [7:0] FSET = FOUR_BIT ? ((ROWS > 1) ? CMD_FSET4_2L : CMD_FSET4_1L)
                                          : ((ROWS > 1) ? CMD_FSET8_2L : CMD_FSET8_1L);
   localparam logic [3:0] INIT_N  = FOUR_BIT ? 4'd9 : 4'd8;
   localparam logic [2:0] ROW_END = 3'(ROWS);
   localparam logic [4:0] COL_END = 5'(COLS);

   function automatic lcd_cmd_t init_cmd(input logic [3:0] step);
      lcd_cmd_t c;
`ifdef LCD_4BIT_MODE_EN
      case (step)
         4'd0:    c = '{1'b1, CMD_WAKE, US_WAKE1};
         4'd1:    c = '{1'b1, CMD_WAKE, US_WAKE2};
         4'd2:    c = '{1'b1, CMD_WAKE, US_CMD};
         4'd3:    c = '{1'b1, CMD_NIB4, US_CMD};
         4'd4:    c = '{1'b0, FSET, US_CMD};
         4'd5:    c = '{1'b0, CMD_DISP_OFF, US_CMD};
         4'd6:    c = '{1'b0, CMD_CLEAR, US_CLEAR};
         4'd7:    c = '{1'b0, CMD_ENTRY, US_CMD};
         default: c = '{1'b0, CMD_DISP_ON, US_CMD};
      endcase
`else
      case (step)
         4'd0:    c = '{1'b0, CMD_WAKE, US_WAKE1};
         4'd1:    c = '{1'b0, CMD_WAKE, US_WAKE2};
         4'd2:    c = '{1'b0, CMD_WAKE, US_CMD};
         4'd3:    c = '{1'b0, FSET, US_CMD};
         4'd4:    c = '{1'b0, CMD_DISP_OFF, US_CMD};
         4'd5:    c = '{1'b0, CMD_CLEAR, US_CLEAR};
         4'd6:    c = '{1'b0, CMD_ENTRY, US_CMD};
         default: c = '{1'b0, CMD_DISP_ON, US_CMD};
      endcase
`endif
      return c;
   endfunction

   ctrl_state_t   state, state_n;
   logic [CW-1:0] pwr_cnt, pwr_n;
   logic [3:0]    step, step_n;
   logic [2:0]    row, row_n;
   logic [4:0]    col, col_n;
   logic          pending, pending_n, done_q, done_n, launch;
   logic [7:0]    char_buf [N];
   logic [AW-1:0] rd_idx;
   logic          x_start, x_rs, x_ready;
   lcd_cmd_t      x_cmd;

   always_ff @(posedge in_Clk) begin
      if (!reset) begin
         state   <= PWR_WAIT;
         pwr_cnt <= '0;
         step    <= '0;
         row     <= '0;
         col     <= '0;
         pending <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_n;
         pwr_cnt <= pwr_n;
         step    <= step_n;
         row     <= row_n;
         col     <= col_n;
         pending <= pending_n;
         done_q  <= done_n;
      end
   end

   always_ff @(posedge in_Clk) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) char_buf[i] <= 8'h20;
      end else if (wr_en && (int'(wr_addr) < N)) begin
         char_buf[wr_addr] <= wr_data;
      end
   end

   // col 0 of each row is the DDRAM address command, cols 1..COLS are characters
   always_comb begin
      state_n   = state;
      pwr_n     = pwr_cnt;
      step_n    = step;
      row_n     = row;
      col_n     = col;
      pending_n = pending;
      done_n    = done_q;
      launch    = 1'b0;
      x_start   = 1'b0;
      x_rs      = 1'b0;
      x_cmd     = '{1'b0, 8'h00, US_CMD};
      rd_idx    = AW'(int'(row) * COLS + int'(col) - 1);
      case (state)
         PWR_WAIT: begin
            pending_n = 1'b0;
            if (pwr_cnt == PWR_END) begin
               state_n = INIT;
               pwr_n   = '0;
            end else begin
               pwr_n = pwr_cnt + CW'(1);
            end
         end
         INIT: begin
            pending_n = 1'b0;
            if (step != INIT_N) begin
               x_start = 1'b1;
               x_cmd   = init_cmd(step);
               if (x_ready) step_n = step + 4'd1;
            end else if (x_ready) begin
               done_n = 1'b1;
               launch = 1'b1;
            end
         end
         DRAW: begin
            if (refresh) pending_n = 1'b1;
            if (row != ROW_END) begin
               x_start = 1'b1;
               if (col == '0) begin
                  x_cmd.code = CMD_DDRAM | row_base(row[1:0]);
               end else begin
                  x_rs       = 1'b1;
                  x_cmd.code = char_buf[rd_idx];
               end
               if (x_ready) begin
                  if (col == COL_END) begin
                     col_n = '0;
                     row_n = row + 3'd1;
                  end else begin
                     col_n = col + 5'd1;
                  end
               end
            end else if (x_ready) begin
               if (pending || refresh) launch = 1'b1;
               else state_n = IDLE;
            end
         end
         IDLE:    if (refresh && x_ready) launch = 1'b1;
         default: state_n = PWR_WAIT;
      endcase
      // a redraw begins by sending row 0's address in the same cycle it is granted
      if (launch) begin
         x_start    = 1'b1;
         x_rs       = 1'b0;
         x_cmd.code = CMD_DDRAM | row_base(2'd0);
         state_n    = DRAW;
         row_n      = '0;
         col_n      = 5'd1;
         pending_n  = 1'b0;
      end
   end

   lcd_byte_xfer #(.CLK_HZ(CLK_HZ)) u_xfer (
      .in_Clk   (in_Clk),
      .reset    (reset),
      .start    (x_start),
      .rs       (x_rs),
      .byte_in  (x_cmd.code),
      .wait_us  (x_cmd.wait_us),
      .nib_only (x_cmd.nib_only),
      .ready    (x_ready),
      .lcd_rs   (lcd_rs),
      .lcd_e    (lcd_e),
      .data     (data)
   );

   assign busy      = (state != IDLE);
   assign init_done = done_q;
   assign lcd_rw    = 1'b0;

endmodule
